// File: rtl/asyn_updown_counter_pkg.sv
// rtl/asyn_updown_counter_pkg.sv - shared width constant and count type for the up/down counter
`timescale 1ns/1ps
package asyn_updown_counter_pkg;

    // Default counter width; count range is 0 .. 2**DEFAULT_WIDTH-1.
    localparam int DEFAULT_WIDTH = 3;

    // Count vector at the default width.
    typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage

// File: rtl/asyn_updown_counter.sv
// rtl/asyn_updown_counter.sv - free-running up/down counter, async active-low reset, optional tc (ASYN_UPDOWN_TC_EN)
`timescale 1ns/1ps
module asyn_updown_counter
    import asyn_updown_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    output logic [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             rst,
    input  logic             updown
`ifdef ASYN_UPDOWN_TC_EN
    ,
    output logic             tc
`endif
);

    // Count register: cleared immediately while rst is low, otherwise steps
    // one up or one down on every rising edge, wrapping modulo 2**WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y <= '0;
        end else if (updown) begin
            y <= y + WIDTH'(1);
        end else begin
            y <= y - WIDTH'(1);
        end
    end

`ifdef ASYN_UPDOWN_TC_EN
    // Terminal count: the next edge in the current direction will wrap.
    always_comb begin
        tc = updown ? (y == '1) : (y == '0);
    end
`endif

endmodule

// File: tb/tb_asyn_updown_counter.sv
// tb/tb_asyn_updown_counter.sv - self-checking bench for asyn_updown_counter with a modular-arithmetic reference model
`timescale 1ns/1ps
module tb_asyn_updown_counter;
    import asyn_updown_counter_pkg::*;

    localparam int W     = DEFAULT_WIDTH;
    localparam int COUNT = 1 << W;

    count_t y;
    logic   clk;
    logic   rst;
    logic   updown;
`ifdef ASYN_UPDOWN_TC_EN
    logic   tc;
`endif

    int tests;
    int fails;
    int exp_y;
    bit check_en;

    asyn_updown_counter #(.WIDTH(W)) dut (
        .y      (y),
        .clk    (clk),
        .rst    (rst),
        .updown (updown)
`ifdef ASYN_UPDOWN_TC_EN
        ,
        .tc     (tc)
`endif
    );

    // 2 ns clock: rising edges at 1, 3, 5 ...
    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int y_val();
        return ($isunknown(y)) ? -1 : int'(y);
    endfunction

    // Reference model: the count moves by +1 or -1 modulo COUNT on each edge
    // seen with reset released; the stimulus zeroes it when it asserts reset.
    always @(posedge clk) begin
        if (rst === 1'b1)
            exp_y = (exp_y + (updown ? 1 : COUNT - 1)) % COUNT;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("cycle_y", y_val(), exp_y);
`ifdef ASYN_UPDOWN_TC_EN
            chk("cycle_tc", int'(tc), int'(updown ? (exp_y == COUNT - 1) : (exp_y == 0)));
`endif
        end
    end

    // Drive direction, take one edge, then check both DUT and model against a literal.
    task automatic step(input logic dir, input int lit, input string name);
        updown = dir;
        @(posedge clk);
        #0.5;
        chk({name, "_model"}, exp_y, lit);
        chk(name, y_val(), lit);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        exp_y    = 0;
        check_en = 1'b0;
        rst      = 1'b0;
        updown   = 1'b0;

        // Reset hold for 10 ns; y stays 0 across edges.
        #1.5;
        check_en = 1'b1;
        #3.7;
        chk("reset_hold_y", y_val(), 0);
`ifdef ASYN_UPDOWN_TC_EN
        chk("tc_y0_down", int'(tc), 1);
        updown = 1'b1;
        #0.1;
        chk("tc_reset_up", int'(tc), 0);
        updown = 1'b0;
`endif
        #5.2;
        // Release in the low phase, count down through the wrap.
        rst = 1'b1;
        step(1'b0, 7, "down_wrap_7");
        step(1'b0, 6, "down_6");
        step(1'b0, 5, "down_5");
        step(1'b0, 4, "down_4");
        // Up through the wrap.
        step(1'b1, 5, "up_5");
        step(1'b1, 6, "up_6");
        step(1'b1, 7, "up_7");
`ifdef ASYN_UPDOWN_TC_EN
        chk("tc_y7_up", int'(tc), 1);
`endif
        step(1'b1, 0, "up_wrap_0");
        step(1'b1, 1, "up_1");
        step(1'b1, 2, "up_2");
        // Direction reversal.
        step(1'b1, 3, "rev_up_3");
`ifdef ASYN_UPDOWN_TC_EN
        chk("tc_y3_up", int'(tc), 0);
        updown = 1'b0;
        #0.1;
        chk("tc_y3_down", int'(tc), 0);
        updown = 1'b1;
`endif
        step(1'b0, 2, "rev_down_2");
        step(1'b1, 3, "pre_async_3");

        // Async assert mid high phase, well before the next rising edge.
        #0.2;
        rst   = 1'b0;
        exp_y = 0;
        #0.1;
        chk("async_clear", y_val(), 0);
        @(negedge clk);
        @(negedge clk);
        #0.5;
        rst = 1'b1;
        step(1'b1, 1, "resume_1");

        // Randomized direction with occasional mid-cycle reset pulses.
        for (int i = 0; i < 300; i++) begin
            updown = 1'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                #($urandom_range(1, 7) * 0.1);
                rst   = 1'b0;
                exp_y = 0;
                #0.05;
                chk("rand_async_clear", y_val(), 0);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1.5;
                rst = 1'b1;
            end
            @(posedge clk);
            #0.5;
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
